// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_pkg
// Purpose  : Shared definitions for the RTC time-setting controller: state
//            encoding, display field codes and BCD digit limits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  // Controller states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } rtc_state_e;

  // Field codes presented to the display for blinking.
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HR   = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // BCD limits for the two editable digit pairs.
  localparam logic [3:0] HR_MAX_T      = 4'd2;
  localparam logic [3:0] HR_MAX_U      = 4'd3;
  localparam logic [3:0] MIN_MAX_T     = 4'd5;
  localparam logic [3:0] MIN_MAX_U     = 4'd9;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Display field associated with a state.
  function automatic logic [1:0] field_of(input rtc_state_e st);
    logic [1:0] f;
    f = FIELD_NONE;
    case (st)
      ST_SET_HR:  f = FIELD_HR;
      ST_SET_MIN: f = FIELD_MIN;
      ST_SET_SEC: f = FIELD_SEC;
      default:    f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/bcd_pair_inc.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pair_inc
// Purpose  : Combinational two-digit BCD incrementer with a configurable
//            upper limit. The limit value and any illegal input (tens above
//            MAX_T, units above 9, or units above MAX_U when tens == MAX_T)
//            wrap to 00.
// Ports    : in_t/in_u   - current tens/units BCD digits
//            out_t/out_u - incremented tens/units BCD digits
// Revision : 1.0 - initial release
// ============================================================================
module bcd_pair_inc
  import rtc_pkg::*;
#(
  parameter logic [3:0] MAX_T = 4'd2,
  parameter logic [3:0] MAX_U = 4'd3
) (
  input  logic [3:0] in_t,
  input  logic [3:0] in_u,
  output logic [3:0] out_t,
  output logic [3:0] out_u
);

  logic w_illegal;
  logic w_at_max;

  always_comb begin
    w_illegal = (in_t > MAX_T) || (in_u > BCD_MAX_DIGIT) ||
                ((in_t == MAX_T) && (in_u > MAX_U));
    w_at_max  = (in_t == MAX_T) && (in_u == MAX_U);

    out_t = in_t;
    out_u = in_u + 4'd1;
    if (w_illegal || w_at_max) begin
      out_t = 4'd0;
      out_u = 4'd0;
    end else if (in_u == BCD_MAX_DIGIT) begin
      out_t = in_t + 4'd1;
      out_u = 4'd0;
    end
  end

endmodule : bcd_pair_inc
`default_nettype wire

// File: rtl/rtc_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rtc_set_ctrl
// Purpose  : Time-setting controller for the BCD RTC counter chain. Freezes
//            the chain while the user edits hours/minutes/seconds in shadow
//            registers via two buttons, then commits with a one-cycle load.
// Ports    : clk_1hz, rst (sync, active-low)
//            btn_mode, btn_inc          - debounced level buttons
//            cur_{hrm,hrl,minm,minl,secm,secl} - live BCD time
//            tick_en                    - RTC count enable
//            load                       - one-cycle commit pulse
//            ld_{hrm,hrl,minm,minl,secm,secl}  - shadow BCD time
//            field                      - field being edited (0 none..3 sec)
// Revision : 1.0 - initial release
// ============================================================================
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hrm,
  input  logic [3:0] cur_hrl,
  input  logic [3:0] cur_minm,
  input  logic [3:0] cur_minl,
  input  logic [3:0] cur_secm,
  input  logic [3:0] cur_secl,
  output logic       tick_en,
  output logic       load,
  output logic [3:0] ld_hrm,
  output logic [3:0] ld_hrl,
  output logic [3:0] ld_minm,
  output logic [3:0] ld_minl,
  output logic [3:0] ld_secm,
  output logic [3:0] ld_secl,
  output logic [1:0] field
);

  localparam int             IDLE_W    = $clog2(TIMEOUT_S + 1);
  // The abort fires on the edge where the counter would reach TIMEOUT_S,
  // i.e. TIMEOUT_S edges after the last button rise.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

  rtc_state_e        state_q, state_d;
  logic              mode_q, inc_q;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              tick_en_q, tick_en_d;
  logic              load_q, load_d;
  logic [1:0]        field_q, field_d;
  logic [3:0]        hrm_q, hrl_q, minm_q, minl_q, secm_q, secl_q;
  logic [3:0]        hrm_d, hrl_d, minm_d, minl_d, secm_d, secl_d;

  logic              mode_rise, inc_rise, in_set;
  logic [3:0]        hr_inc_t, hr_inc_u, min_inc_t, min_inc_u;

  bcd_pair_inc #(
    .MAX_T (HR_MAX_T),
    .MAX_U (HR_MAX_U)
  ) u_hr_inc (
    .in_t  (hrm_q),
    .in_u  (hrl_q),
    .out_t (hr_inc_t),
    .out_u (hr_inc_u)
  );

  bcd_pair_inc #(
    .MAX_T (MIN_MAX_T),
    .MAX_U (MIN_MAX_U)
  ) u_min_inc (
    .in_t  (minm_q),
    .in_u  (minl_q),
    .out_t (min_inc_t),
    .out_u (min_inc_u)
  );

  always_comb begin
    mode_rise = btn_mode & ~mode_q;
    // Mode wins a simultaneous press; the inc edge is dropped.
    inc_rise  = btn_inc & ~inc_q & ~mode_rise;
    in_set    = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) ||
                (state_q == ST_SET_SEC);

    state_d = state_q;
    idle_d  = idle_q;
    hrm_d   = hrm_q;
    hrl_d   = hrl_q;
    minm_d  = minm_q;
    minl_d  = minl_q;
    secm_d  = secm_q;
    secl_d  = secl_q;

    // Inactivity abort: shared by all edit states, shadows left untouched.
    if (in_set) begin
      if (mode_rise || inc_rise) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        idle_d  = '0;
        state_d = ST_RUN;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (mode_rise) begin
          hrm_d   = cur_hrm;
          hrl_d   = cur_hrl;
          minm_d  = cur_minm;
          minl_d  = cur_minl;
          secm_d  = cur_secm;
          secl_d  = cur_secl;
          idle_d  = '0;
          state_d = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (mode_rise) begin
          state_d = ST_SET_MIN;
        end else if (inc_rise) begin
          hrm_d = hr_inc_t;
          hrl_d = hr_inc_u;
        end
      end
      ST_SET_MIN: begin
        if (mode_rise) begin
          state_d = ST_SET_SEC;
        end else if (inc_rise) begin
          minm_d = min_inc_t;
          minl_d = min_inc_u;
        end
      end
      ST_SET_SEC: begin
        if (mode_rise) begin
          state_d = ST_COMMIT;
        end else if (inc_rise) begin
          secm_d = 4'd0;
          secl_d = 4'd0;
        end
      end
      ST_COMMIT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    tick_en_d = (state_d == ST_RUN);
    load_d    = (state_d == ST_COMMIT);
    field_d   = field_of(state_d);
  end

  always_ff @(posedge clk_1hz) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      // Held high so a button pressed through reset gives no edge.
      mode_q    <= 1'b1;
      inc_q     <= 1'b1;
      idle_q    <= '0;
      tick_en_q <= 1'b1;
      load_q    <= 1'b0;
      field_q   <= FIELD_NONE;
      hrm_q     <= 4'd0;
      hrl_q     <= 4'd0;
      minm_q    <= 4'd0;
      minl_q    <= 4'd0;
      secm_q    <= 4'd0;
      secl_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      mode_q    <= btn_mode;
      inc_q     <= btn_inc;
      idle_q    <= idle_d;
      tick_en_q <= tick_en_d;
      load_q    <= load_d;
      field_q   <= field_d;
      hrm_q     <= hrm_d;
      hrl_q     <= hrl_d;
      minm_q    <= minm_d;
      minl_q    <= minl_d;
      secm_q    <= secm_d;
      secl_q    <= secl_d;
    end
  end

  assign tick_en = tick_en_q;
  assign load    = load_q;
  assign field   = field_q;
  assign ld_hrm  = hrm_q;
  assign ld_hrl  = hrl_q;
  assign ld_minm = minm_q;
  assign ld_minl = minl_q;
  assign ld_secm = secm_q;
  assign ld_secl = secl_q;

endmodule : rtc_set_ctrl
`default_nettype wire

// File: tb/tb_rtc_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_set_ctrl
// Purpose  : Directed self-checking bench for rtc_set_ctrl.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_set_ctrl;

  logic       clk_1hz;
  logic       rst;
  logic       btn_mode, btn_inc;
  logic [3:0] cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl;
  logic       tick_en, load;
  logic [3:0] ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl;
  logic [1:0] field;
  logic [23:0] ld_all;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_set_ctrl #(.TIMEOUT_S(30)) dut (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_hrm  (cur_hrm),
    .cur_hrl  (cur_hrl),
    .cur_minm (cur_minm),
    .cur_minl (cur_minl),
    .cur_secm (cur_secm),
    .cur_secl (cur_secl),
    .tick_en  (tick_en),
    .load     (load),
    .ld_hrm   (ld_hrm),
    .ld_hrl   (ld_hrl),
    .ld_minm  (ld_minm),
    .ld_minl  (ld_minl),
    .ld_secm  (ld_secm),
    .ld_secl  (ld_secl),
    .field    (field)
  );

  assign ld_all = {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl};

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl} = t;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    tick();
    btn_inc = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst      = 1'b0;
    btn_mode = 1'b1;   // held through reset
    btn_inc  = 1'b0;
    set_cur(24'h123456);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_field",   field,   2'd0);
    chk("rst_tick_en", tick_en, 1'b1);
    chk("rst_load",    load,    1'b0);
    chk("rst_ld",      ld_all,  24'h000000);
    btn_mode = 1'b0;
    tick();
    chk("held_no_edge_field", field, 2'd0);

    // Capture 12:34:56, hours +1, then simultaneous mode+inc.
    press_mode();
    chk("cap_field",   field,   2'd1);
    chk("cap_tick_en", tick_en, 1'b0);
    chk("cap_ld",      ld_all,  24'h123456);
    press_inc();
    chk("hr_12_inc", ld_all, 24'h133456);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    tick();
    chk("simul_field", field,  2'd2);
    chk("simul_ld",    ld_all, 24'h133456);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

    // Idle in SET_MIN: 29 edges stays, 30th edge aborts without load.
    for (int i = 1; i < 30; i++) begin
      tick();
      chk("to_wait_load",  load,  1'b0);
      chk("to_wait_field", field, 2'd2);
    end
    tick();
    chk("to_field",   field,   2'd0);
    chk("to_tick_en", tick_en, 1'b1);
    chk("to_load",    load,    1'b0);
    chk("to_ld",      ld_all,  24'h133456);

    // Hours 22 -> 23 -> 00, minutes 59 -> 00, then reset mid-edit.
    set_cur(24'h225956);
    press_mode();
    chk("cap2_ld", ld_all, 24'h225956);
    press_inc();
    chk("hr_22_inc", ld_all, 24'h235956);
    press_inc();
    chk("hr_23_wrap", ld_all, 24'h005956);
    press_mode();
    chk("min_field", field, 2'd2);
    press_inc();
    chk("min_59_wrap", ld_all, 24'h000056);
    press_mode();
    chk("sec_field", field, 2'd3);
    rst = 1'b0;
    tick();
    chk("mrst_field",   field,   2'd0);
    chk("mrst_tick_en", tick_en, 1'b1);
    chk("mrst_load",    load,    1'b0);
    chk("mrst_ld",      ld_all,  24'h000000);
    rst = 1'b1;
    tick();
    chk("mrst_tick_en2", tick_en, 1'b1);

    // Hours 09 -> 10, minutes 19 -> 20.
    set_cur(24'h091933);
    press_mode();
    press_inc();
    chk("hr_09_inc", ld_all, 24'h101933);
    press_mode();
    press_inc();
    chk("min_19_inc", ld_all, 24'h102033);
    pulse_rst();

    // Illegal captures: hours 27 and minutes 63 both increment to 00.
    set_cur(24'h276300);
    press_mode();
    chk("cap_illegal", ld_all, 24'h276300);
    press_inc();
    chk("hr_27_inc", ld_all, 24'h006300);
    press_mode();
    press_inc();
    chk("min_63_inc", ld_all, 24'h000000);
    pulse_rst();

    // Full edit 07:45:12 -> clear seconds -> commit.
    set_cur(24'h074512);
    press_mode();
    chk("full_cap", ld_all, 24'h074512);
    press_mode();
    press_mode();
    chk("full_sec_field", field, 2'd3);
    press_inc();
    chk("sec_clear", ld_all, 24'h074500);
    btn_mode = 1'b1;
    tick();
    chk("commit_load",    load,    1'b1);
    chk("commit_tick_en", tick_en, 1'b0);
    chk("commit_field",   field,   2'd0);
    chk("commit_ld",      ld_all,  24'h074500);
    btn_mode = 1'b0;
    tick();
    chk("post_load",    load,    1'b0);
    chk("post_tick_en", tick_en, 1'b1);
    chk("post_field",   field,   2'd0);
    tick();
    chk("post2_load", load, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rtc_set_ctrl
`default_nettype wire

// File: doc/rtc_set_ctrl.md
# rtc_set_ctrl

Time-setting controller for the BCD real-time clock counter chain. It gates the chain's count enable and lets a user edit hours, minutes and seconds through a two-button interface (mode, increment) using shadow registers. It commits the edited time with a one-cycle load pulse. It sits between the debounced button inputs and the load/enable ports of the RTC core, in the `clk_1hz` domain.

## Interface
Parameters:
- `TIMEOUT_S`, default 30: idle cycles in any set state before aborting to RUN without committing.

Ports:
- `clk_1hz`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `btn_mode`  in  1  mode button; already synchronised and debounced, level.
- `btn_inc`  in  1  increment button; already synchronised and debounced, level.
- `cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl`  in  4 each  live BCD time from the RTC core.
- `tick_en`  out  1  count enable for the RTC chain.
- `load`  out  1  one-cycle pulse; RTC core loads `ld_*` on this edge.
- `ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl`  out  4 each  shadow BCD time.
- `field`  out  2  field being edited, for display blink: 0 none, 1 hours, 2 minutes, 3 seconds.

## Operation
- Edge detect: `mode_rise = btn_mode & ~mode_q` and `inc_rise = btn_inc & ~inc_q`.
  - `mode_q` and `inc_q` reset to 1, so a button held through reset produces no edge.
- State machine, with states RUN, SET_HR, SET_MIN, SET_SEC, COMMIT:
  - RUN: `tick_en`=1, `field`=0. On `mode_rise`, capture all `cur_*` into the shadow registers and go to SET_HR.
  - SET_HR: `field`=1. On `inc_rise`, increment the hours. On `mode_rise`, go to SET_MIN.
  - SET_MIN: `field`=2. On `inc_rise`, increment the minutes. On `mode_rise`, go to SET_SEC.
  - SET_SEC: `field`=3. On `inc_rise`, clear the seconds to 00. On `mode_rise`, go to COMMIT.
  - COMMIT: `load`=1, `field`=0. Go to RUN unconditionally after one cycle.
- `tick_en`=0 in every state except RUN.
- Hours increment:
  - 23 wraps to 00.
  - Units digit 9 gives units 0 and tens+1.
  - Any illegal captured value (tens>2, units>9, or 24–29) increments to 00.
- Minutes increment:
  - 59 wraps to 00.
  - Units digit 9 gives units 0 and tens+1.
  - Any illegal value increments to 00.
- Seconds: `inc_rise` forces `ld_secm`/`ld_secl` to 0/0.
- Simultaneous `mode_rise` and `inc_rise`: mode wins and the inc edge is discarded.
- Timeout:
  - The idle counter, `$clog2(TIMEOUT_S+1)` bits wide, clears on entry to SET_HR and on any button rise.
  - It increments once per cycle while in the SET_* states.
  - On reaching `TIMEOUT_S`, go to RUN with no `load`; the shadow registers are left as they are.
- `ld_*` are driven continuously from the shadow registers. They are valid whenever `load`=1.
- Reset, including mid-edit: state RUN, `tick_en`=1, `load`=0, `field`=0, all shadow digits 0, idle counter 0.

## Timing
- All outputs are registered and change only on the `clk_1hz` rising edge.
- `mode_rise` sampled at edge N:
  - The state changes at N.
  - `tick_en` drops after N.
  - The shadow registers hold the `cur_*` values sampled at N.
- `inc_rise` at edge N: the new shadow value is visible after N.
- COMMIT:
  - Exactly one cycle with `load`=1 and `tick_en`=0.
  - The RTC core loads on that edge.
  - `tick_en`=1 from the following cycle, so the loaded time first advances one edge after the load.
- Minimum full edit, mode pressed four times: RUN→SET_HR→SET_MIN→SET_SEC→COMMIT→RUN. The RTC is frozen for (edit cycles + 1).
- Timeout abort occurs `TIMEOUT_S` cycles after the last button rise.

## Structure
- Shared package `rtc_pkg`:
  - State enum for RUN/SET_HR/SET_MIN/SET_SEC/COMMIT.
  - `field` codes.
  - BCD limits: HR_MAX_T=2, HR_MAX_U=3, MIN_MAX_T=5, MIN_MAX_U=9.
- One sub-module, `bcd_pair_inc`:
  - Combinational two-digit BCD incrementer.
  - Parameterised by max tens and max units at max tens.
  - Outputs wrap-to-00 on the limit or on illegal input.
  - Instantiated twice, for hours and minutes.

## Test plan
- Reset with `btn_mode` held high → no edge, RUN, `tick_en`=1, `load`=0, all `ld_*`=0.
- Live time 12:34:56, mode pressed → SET_HR, `ld_*`=1,2,3,4,5,6, `tick_en`=0, `field`=1.
- Hours 22, inc ×2 → 23 then 00. Hours 09, inc → 10. Minutes 59, inc → 00. Minutes 19, inc → 20.
- Full sequence: set 07:45:00, then mode through COMMIT → exactly one `load` cycle with `ld_*`=0,7,4,5,0,0, then `tick_en`=1 in RUN.
- Mode and inc rise on the same edge in SET_HR → SET_MIN, hours unchanged. No buttons for `TIMEOUT_S`=30 cycles in SET_MIN → RUN, `load` never asserted.
- `rst` low during SET_SEC → RUN, shadow registers cleared, `tick_en`=1 on the next cycle.
